// File: rtl/bullet_pool_arbiter.sv
// Shared bullet pool for two tanks: fire edge detect, cooldown, live cap,
// round-robin arbitration, lowest-free-slot allocation and per-frame motion.
module bullet_pool_arbiter #(
  parameter int NSLOT        = 4,
  parameter int PER_TANK_MAX = 2,
  parameter int COOLDOWN     = 15,
  parameter int LIFETIME     = 240,
  parameter int STEP         = 2,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 479
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic                  fire1,
  input  logic                  fire2,
  input  logic [9:0]            tank1_x,
  input  logic [9:0]            tank1_y,
  input  logic [9:0]            tank2_x,
  input  logic [9:0]            tank2_y,
  input  logic [1:0]            tank1_dir,
  input  logic [1:0]            tank2_dir,
  output logic [NSLOT-1:0]      bullet_active,
  output logic [NSLOT-1:0]      bullet_owner,
  output logic [10*NSLOT-1:0]   bullet_x,
  output logic [10*NSLOT-1:0]   bullet_y,
  output logic                  grant1,
  output logic                  grant2
);
  localparam int SW  = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int CNW = $clog2(NSLOT + 1);
  localparam int LW  = $clog2(LIFETIME + 1);
  localparam int CW  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic signed [10:0] S_STEP = 11'(STEP);
  localparam logic signed [10:0] S_XMIN = 11'(X_MIN);
  localparam logic signed [10:0] S_XMAX = 11'(X_MAX);
  localparam logic signed [10:0] S_YMIN = 11'(Y_MIN);
  localparam logic signed [10:0] S_YMAX = 11'(Y_MAX);

  logic                r_fire1_q, r_fire2_q;
  logic                r_pend1, r_pend2, r_rr;
  logic [CW-1:0]       r_cd1, r_cd2;
  logic                r_grant1, r_grant2;
  logic [NSLOT-1:0]    r_active, r_owner;
  logic [9:0]          r_x [NSLOT];
  logic [9:0]          r_y [NSLOT];
  logic signed [10:0]  r_dx [NSLOT];
  logic signed [10:0]  r_dy [NSLOT];
  logic [LW-1:0]       r_life [NSLOT];

  logic [CNW-1:0]      w_cnt1, w_cnt2;
  logic                w_found;
  logic [SW-1:0]       w_slot;
  logic                w_ok1, w_ok2;
  logic                w_win1, w_win2;
  logic                w_pend1_n, w_pend2_n, w_rr_n;
  logic [1:0]          w_dir;
  logic [9:0]          w_sx, w_sy;
  logic signed [10:0]  w_vx, w_vy;
  logic signed [10:0]  w_nx [NSLOT];
  logic signed [10:0]  w_ny [NSLOT];
  logic [NSLOT-1:0]    w_bx, w_by;

  // descending scan leaves the lowest free index in w_slot
  always_comb begin
    w_cnt1  = '0;
    w_cnt2  = '0;
    w_found = 1'b0;
    w_slot  = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_found = 1'b1;
        w_slot  = SW'(i);
      end
      if (r_active[i] && !r_owner[i]) w_cnt1 = w_cnt1 + 1'b1;
      if (r_active[i] && r_owner[i])  w_cnt2 = w_cnt2 + 1'b1;
    end
  end

  always_comb begin
    w_ok1 = ((fire1 & ~r_fire1_q) | r_pend1)
          && (r_cd1 == '0)
          && (w_cnt1 < CNW'(PER_TANK_MAX))
          && w_found;
    w_ok2 = ((fire2 & ~r_fire2_q) | r_pend2)
          && (r_cd2 == '0)
          && (w_cnt2 < CNW'(PER_TANK_MAX))
          && w_found;
  end

  // a pending loser outranks a fresh event; otherwise rr decides
  always_comb begin
    w_win1    = 1'b0;
    w_win2    = 1'b0;
    w_pend1_n = 1'b0;
    w_pend2_n = 1'b0;
    w_rr_n    = r_rr;
    if (w_ok1 && w_ok2) begin
      w_win1    = r_pend1 | (~r_pend2 & ~r_rr);
      w_win2    = ~w_win1;
      w_pend1_n = w_win2;
      w_pend2_n = w_win1;
      w_rr_n    = w_win1;
    end else begin
      w_win1 = w_ok1;
      w_win2 = w_ok2;
    end
  end

  always_comb begin
    w_dir = w_win2 ? tank2_dir : tank1_dir;
    w_sx  = w_win2 ? tank2_x : tank1_x;
    w_sy  = w_win2 ? tank2_y : tank1_y;
    w_vx  = '0;
    w_vy  = '0;
    unique case (w_dir)
      2'd0:    w_vy = -S_STEP;
      2'd1:    w_vx = S_STEP;
      2'd2:    w_vy = S_STEP;
      default: w_vx = -S_STEP;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      w_nx[i] = $signed({1'b0, r_x[i]}) + r_dx[i];
      w_ny[i] = $signed({1'b0, r_y[i]}) + r_dy[i];
      w_bx[i] = (w_nx[i] < S_XMIN) || (w_nx[i] > S_XMAX);
      w_by[i] = (w_ny[i] < S_YMIN) || (w_ny[i] > S_YMAX);
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_fire1_q <= 1'b1;
      r_fire2_q <= 1'b1;
      r_pend1   <= 1'b0;
      r_pend2   <= 1'b0;
      r_rr      <= 1'b0;
      r_cd1     <= '0;
      r_cd2     <= '0;
      r_grant1  <= 1'b0;
      r_grant2  <= 1'b0;
      r_active  <= '0;
      r_owner   <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        r_x[i]    <= '0;
        r_y[i]    <= '0;
        r_dx[i]   <= '0;
        r_dy[i]   <= '0;
        r_life[i] <= '0;
      end
    end else begin
      r_fire1_q <= fire1;
      r_fire2_q <= fire2;
      r_pend1   <= w_pend1_n;
      r_pend2   <= w_pend2_n;
      r_rr      <= w_rr_n;
      r_grant1  <= w_win1;
      r_grant2  <= w_win2;
      if (w_win1)              r_cd1 <= CW'(COOLDOWN);
      else if (r_cd1 != '0)    r_cd1 <= r_cd1 - 1'b1;
      if (w_win2)              r_cd2 <= CW'(COOLDOWN);
      else if (r_cd2 != '0)    r_cd2 <= r_cd2 - 1'b1;
      for (int i = 0; i < NSLOT; i++) begin
        if ((w_win1 | w_win2) && (w_slot == SW'(i))) begin
          r_active[i] <= 1'b1;
          r_owner[i]  <= w_win2;
          r_x[i]      <= w_sx;
          r_y[i]      <= w_sy;
          r_dx[i]     <= w_vx;
          r_dy[i]     <= w_vy;
          r_life[i]   <= LW'(LIFETIME);
        end else if (r_active[i]) begin
          if (r_life[i] == LW'(1)) begin
            r_active[i] <= 1'b0;
            r_life[i]   <= '0;
          end else begin
            r_life[i] <= r_life[i] - 1'b1;
            if (w_bx[i]) r_dx[i] <= -r_dx[i];
            else         r_x[i]  <= w_nx[i][9:0];
            if (w_by[i]) r_dy[i] <= -r_dy[i];
            else         r_y[i]  <= w_ny[i][9:0];
          end
        end
      end
    end
  end

  always_comb begin
    bullet_x = '0;
    bullet_y = '0;
    for (int i = 0; i < NSLOT; i++) begin
      bullet_x[10*i +: 10] = r_x[i];
      bullet_y[10*i +: 10] = r_y[i];
    end
  end

  assign bullet_active = r_active;
  assign bullet_owner  = r_owner;
  assign grant1        = r_grant1;
  assign grant2        = r_grant2;

endmodule

// File: doc/bullet_pool_arbiter.md
Name: bullet_pool_arbiter

Overview:
- Shares a fixed pool of bullet slots between the two tank controllers.
- Edge-detects each tank's fire input and applies a per-tank cooldown and a per-tank live-bullet cap.
- Arbitrates simultaneous shots round-robin and allocates the lowest free slot.
- Moves, bounces and expires every live bullet once per frame; slot outputs feed the colour mapper and the hit detector.

Parameters:
- NSLOT, 4, bullet slots in the pool (2..8)
- PER_TANK_MAX, 2, live bullets allowed per tank
- COOLDOWN, 15, frames after a grant before that tank is eligible again
- LIFETIME, 240, frames a bullet stays active
- STEP, 2, bullet speed in pixels per frame
- X_MIN, 0 / X_MAX, 639 / Y_MIN, 0 / Y_MAX, 479, playfield bounds (inclusive)

Ports:
- frame_clk  in  1  frame-rate clock
- Reset  in  1  reset
- fire1, fire2  in  1 each  level fire key, tank 1 / tank 2
- tank1_x, tank1_y, tank2_x, tank2_y  in  10 each  tank centre position
- tank1_dir, tank2_dir  in  2 each  facing direction: 0=up, 1=right, 2=down, 3=left
- bullet_active  out  NSLOT  slot i live
- bullet_owner  out  NSLOT  slot i owner: 0=tank1, 1=tank2
- bullet_x, bullet_y  out  10*NSLOT each  packed positions, slot i at [10i+9:10i]
- grant1, grant2  out  1 each  one-frame pulse when that tank's shot is allocated

Behaviour:
- Reset (asynchronous, active-high, clock frame_clk) takes effect immediately. It clears:
  - all bullet_active, bullet_owner, bullet_x, bullet_y, per-slot dx, dy and life counters
  - grant1, grant2, both cooldown counters and both pending flags
  - the round-robin pointer, which is set to tank1
- The fire edge registers reset to 1, so a fire key held across reset release produces no shot.
- Request event for tank t: fire_t=1 while the registered previous value is 0.
- Eligibility is checked at the event edge: cooldown_t==0, live_count_t<PER_TANK_MAX, and at least one free slot.
  - An ineligible event is dropped, not queued.
- Arbitration, at most one allocation per frame:
  - One eligible requester: it is granted.
  - Both eligible in the same frame: the tank named by the rr pointer wins. The loser sets pending_t and is re-evaluated next frame with normal eligibility rules; a pending tank outranks any new event.
  - The rr pointer flips to the non-winner after every two-way contention.
- Allocation at edge k:
  - Slot: lowest-index slot with active=0 before edge k. A slot that expires at edge k is not reusable until edge k+1.
  - Slot load: active=1, owner=t, x/y=tank centre, life=LIFETIME.
  - Velocity by direction: up (dx=0, dy=-STEP), right (+STEP, 0), down (0, +STEP), left (-STEP, 0).
  - grant_t=1 for exactly the cycle after edge k.
  - cooldown_t loads COOLDOWN and decrements by 1 per frame to 0.
- Motion: a live slot that was not allocated at this edge computes nx=x+dx and ny=y+dy in 11-bit signed arithmetic.
  - If nx<X_MIN or nx>X_MAX: dx negates and x holds.
  - Otherwise x<=nx. Y uses the same rule, independently.
  - Both axes may bounce in the same frame.
- Expiry: life decrements by 1 each moving frame.
  - When life==1 at an edge, the slot goes active=0 at that edge. A bullet is therefore visible for exactly LIFETIME frames.
  - x/y hold their last value after expiry; consumers must gate on bullet_active.
- live_count_t is the number of active slots with owner==t, computed combinationally from slot state.
- No combinational path from fire inputs to any output; all outputs are registered.

Test Plan:
- Reset, hold fire1=1 through release → no grant1, bullet_active=0 for 20 frames.
- tank1 at (320,240), dir=1, fire1 rise at edge k → grant1 pulse, slot0 active at (320,240); x=322 at k+1, x=330 at k+5.
- fire1 and fire2 rise same edge, rr=tank1 → tank1 gets slot0 at k, tank2 gets slot1 at k+1. Repeat the contention with both cooldowns at 0 → tank2 wins.
- tank1 fires 3 times, 16 frames apart → third request dropped (PER_TANK_MAX=2). A retry 2 frames apart → dropped by cooldown.
- Bullet at x=638, dx=+2 → x holds at 638, dx=-2, next frame x=636. Corner at (1,1) moving up → y bounce only.
- Spawn at edge k → active through edge k+239, inactive after edge k+240. Freed slot reused by a request at k+241, not at k+240. Assert Reset mid-flight → all slots inactive immediately.
